// File: rtl/prewish_mask_player.sv
// Buffers up to four 8-bit LED masks offered over a strobe handshake and plays
// them MSB first on o_led, one bit per divider tick, replaying the last mask when idle.
module prewish_mask_player #(
   parameter int unsigned SYSCLK_DIV_BITS = 21
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       STB_I,
   input  logic [7:0] DAT_I,
   output logic       ACK_O,
   output logic       o_full,
   output logic       o_ovf,
   output logic       o_led,
   output logic       o_alive
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t                     state, state_n;
   logic                       stb_q;
   logic [SYSCLK_DIV_BITS-1:0] div;
   logic                       tick;

   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count, count_n;
   logic [7:0] head;

   logic [7:0] cur, cur_n;
   logic [2:0] idx, idx_n;
   logic       led_n;
   logic       accept, push, drop, pop;

   assign accept  = STB_I & ~stb_q;
   // Fullness is judged on the pre-pop count, so a same-cycle pop cannot make room.
   assign push    = accept & (count != 3'd4);
   assign drop    = accept & (count == 3'd4);
   assign tick    = &div;
   assign head    = mem[rd_ptr];
   assign o_alive = div[SYSCLK_DIV_BITS-1];
   assign count_n = count + {2'b00, push} - {2'b00, pop};

   always_comb begin
      state_n = state;
      cur_n   = cur;
      idx_n   = idx;
      led_n   = o_led;
      pop     = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (count != 3'd0) begin
                  pop     = 1'b1;
                  cur_n   = head;
                  idx_n   = 3'd7;
                  led_n   = head[7];
                  state_n = PLAY;
               end
            end
            default: begin
               if (idx != 3'd0) begin
                  idx_n = idx - 3'd1;
                  led_n = cur[idx - 3'd1];
               end else if (count != 3'd0) begin
                  pop   = 1'b1;
                  cur_n = head;
                  idx_n = 3'd7;
                  led_n = head[7];
               end else begin
                  idx_n = 3'd7;
                  led_n = cur[7];
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state  <= IDLE;
         stb_q  <= 1'b0;
         div    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cur    <= '0;
         idx    <= '0;
         o_led  <= 1'b0;
         ACK_O  <= 1'b0;
         o_full <= 1'b0;
         o_ovf  <= 1'b0;
      end else begin
         state  <= state_n;
         stb_q  <= STB_I;
         div    <= div + 1'b1;
         cur    <= cur_n;
         idx    <= idx_n;
         o_led  <= led_n;
         ACK_O  <= push;
         o_full <= (count_n == 3'd4);
         o_ovf  <= o_ovf | drop;
         count  <= count_n;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
      end
   end

   // Storage needs no reset: entry validity is carried entirely by count.
   always_ff @(posedge CLK_I) begin
      if (push) mem[wr_ptr] <= DAT_I;
   end

endmodule

// File: doc/prewish_mask_player.md
PREWISH_MASK_PLAYER -- requirements
Module: prewish_mask_player

Interface
REQ-001 SHALL have parameter SYSCLK_DIV_BITS, default 21, giving bit-tick divider width (bit period = 2^SYSCLK_DIV_BITS clocks).
REQ-002 SHALL have port CLK_I  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_I  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port STB_I  input  1  strobe from mentor; a rising edge offers a new mask.
REQ-005 SHALL have port DAT_I  input  8  mask offered with STB_I.
REQ-006 SHALL have port ACK_O  output  1  one-cycle pulse: mask accepted into buffer.
REQ-007 SHALL have port o_full  output  1  high while buffer holds 4 masks.
REQ-008 SHALL have port o_ovf  output  1  sticky: a mask was dropped because buffer full.
REQ-009 SHALL have port o_led  output  1  serial mask playback, active high.
REQ-010 SHALL have port o_alive  output  1  divider MSB, free-running heartbeat.

Function
REQ-011 SHALL register STB_I each cycle (stb_q); accept event = STB_I & ~stb_q; a strobe held high any number of cycles SHALL yield exactly one accept.
REQ-012 SHALL buffer masks in a 4-entry FIFO: 2-bit wr/rd pointers wrapping 3->0, 3-bit count 0..4.
REQ-013 On accept with count<4: write DAT_I at wr_ptr, increment wr_ptr and count, assert ACK_O on the following cycle for exactly one cycle.
REQ-014 On accept with count==4 (evaluated before any same-cycle pop): discard DAT_I, no ACK_O, set o_ovf; o_ovf SHALL stay high until reset.
REQ-015 o_full SHALL equal (count==4), registered with count.
REQ-016 Divider SHALL be a free-running SYSCLK_DIV_BITS-bit up counter wrapping to 0; tick = counter all ones; o_alive = counter MSB.
REQ-017 Player FSM SHALL have states IDLE and PLAY, plus 8-bit shift register cur and 3-bit bit index idx.
REQ-018 IDLE: o_led=0; on tick with count>0, pop head into cur, idx<=7, o_led<=head[7], go PLAY; on tick with count==0, stay IDLE.
REQ-019 PLAY, tick with idx>0: idx<=idx-1, o_led<=cur[idx-1].
REQ-020 PLAY, tick with idx==0 and count>0: pop head into cur, idx<=7, o_led<=head[7].
REQ-021 PLAY, tick with idx==0 and count==0: replay cur: idx<=7, o_led<=cur[7]; FSM SHALL never return to IDLE except via reset.
REQ-022 Between ticks, o_led, cur, idx SHALL hold.
REQ-023 Same-cycle accept and pop: count SHALL be unchanged when both succeed; accept into an empty FIFO SHALL NOT be visible to a pop in the same cycle (pop sees count==0).
REQ-024 Every mask SHALL be shown for at least 8 bit periods, MSB first; a newly accepted mask SHALL appear only at the first tick after the current mask's bit 0 period completes.

Reset
REQ-025 While RST_I=0: ACK_O=0, o_full=0, o_ovf=0, o_led=0, o_alive=0, divider=0, count=0, pointers=0, stb_q=0, cur=0, idx=0, state IDLE; asynchronous assertion SHALL abort playback and clear FIFO contents' validity immediately.
REQ-026 If STB_I is already high on the first clock after RST_I deasserts, that SHALL count as an accept (stb_q starts 0).

Verification (SYSCLK_DIV_BITS=2, tick every 4th clock)
REQ-027 Reset release, STB_I pulse 1 cycle with DAT_I=8'hA8 -> ACK_O one cycle later; o_led over next 8 ticks = 1,0,1,0,1,0,0,0, then repeats.
REQ-028 STB_I held high 20 cycles with DAT_I=8'h80 -> exactly one ACK_O pulse, count=1.
REQ-029 Five strobes (8'h80,8'hA0,8'hA8,8'hFF,8'hD4) while IDLE with no tick -> 4 ACKs, o_full=1, fifth no ACK, o_ovf=1 and stays 1; playback order 80,A0,A8,FF.
REQ-030 Playing 8'hCC, push 8'h55 mid-mask -> remaining CC bits finish, 55 starts at next tick after CC bit 0.
REQ-031 Accept coinciding with pop at count==4 -> mask dropped, o_ovf=1, count 3 after; accept coinciding with pop at count==2 -> ACK, count stays 2.
REQ-032 Assert RST_I low mid-mask -> o_led=0, o_full=0, o_ovf=0 immediately; after release, no playback until a new accept.
